// File: rtl/store_commit_buffer.sv
// In-order buffer of retired stores that drains to data memory over valid/ready and answers load forwarding/stall lookups.
// Store pushed on edge N requests memory in cycle N+1; pop when mem_req&&mem_ready; sb_full holds off further store retirement.
module store_commit_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] commit_addr,
  input  logic [31:0] commit_data,
  input  logic [2:0]  commit_funct3,
  output logic        sb_full,
  output logic        sb_empty,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_stall,
  output logic        ld_fwd_valid,
  output logic [31:0] ld_fwd_data,
  output logic        err_misaligned,
  output logic        err_overflow
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0] r_vld;
  logic [29:0]      r_addr  [DEPTH];
  logic [31:0]      r_wdata [DEPTH];
  logic [3:0]       r_wstrb [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_err_mis;
  logic             r_err_ovf;

  logic        w_legal;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic        w_pop;
  logic        w_push;
  logic        w_full;
  logic        w_hit;
  logic        w_hit_full;
  logic [31:0] w_hit_data;
  logic [PTR_W-1:0] w_idx;
  logic        w_ld_unused;

  assign w_ld_unused = &{1'b0, ld_addr[1:0]};

  // Lane placement and legality of the retiring store
  always_comb begin
    w_legal = 1'b0;
    w_wstrb = 4'b0000;
    w_wdata = commit_data;
    case (commit_funct3)
      3'b000: begin
        w_legal = 1'b1;
        w_wstrb = 4'b0001 << commit_addr[1:0];
        w_wdata = {4{commit_data[7:0]}};
      end
      3'b001: begin
        w_legal = ~commit_addr[0];
        w_wstrb = 4'b0011 << {commit_addr[1], 1'b0};
        w_wdata = {2{commit_data[15:0]}};
      end
      3'b010: begin
        w_legal = (commit_addr[1:0] == 2'b00);
        w_wstrb = 4'b1111;
        w_wdata = commit_data;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  assign w_full   = (r_count == FULL_CNT);
  assign mem_req  = r_vld[r_head];
  assign w_pop    = mem_req && mem_ready;
  // A full buffer still accepts a store when the head leaves on the same edge
  assign w_push   = commit_valid && w_legal && (!w_full || w_pop);

  assign sb_full   = w_full;
  assign sb_empty  = (r_count == '0);
  assign mem_addr  = {r_addr[r_head], 2'b00};
  assign mem_wdata = r_wdata[r_head];
  assign mem_wstrb = r_wstrb[r_head];
  assign err_misaligned = r_err_mis;
  assign err_overflow   = r_err_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld     <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_err_mis <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      r_err_mis <= commit_valid && !w_legal;
      if (commit_valid && w_full && !w_pop) begin
        r_err_ovf <= 1'b1;
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail]  <= commit_addr[31:2];
      r_wdata[r_tail] <= w_wdata;
      r_wstrb[r_tail] <= w_wstrb;
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest store
  always_comb begin
    w_hit      = 1'b0;
    w_hit_full = 1'b0;
    w_hit_data = '0;
    w_idx      = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (r_vld[w_idx] && (r_addr[w_idx] == ld_addr[31:2])) begin
        w_hit      = 1'b1;
        w_hit_full = (r_wstrb[w_idx] == 4'b1111);
        w_hit_data = r_wdata[w_idx];
      end
    end
  end

  assign ld_fwd_valid = ld_valid && w_hit && w_hit_full;
  assign ld_stall     = ld_valid && w_hit && !w_hit_full;
  assign ld_fwd_data  = ld_fwd_valid ? w_hit_data : 32'h0;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer: lane-placement vector table plus hand-written full/wrap, forwarding and reset sequences.
module tb_store_commit_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [31:0] commit_addr;
  logic [31:0] commit_data;
  logic [2:0]  commit_funct3;
  logic        sb_full, sb_empty, mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall, ld_fwd_valid;
  logic [31:0] ld_fwd_data;
  logic        err_misaligned, err_overflow;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  store_commit_buffer #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_addr(commit_addr),
    .commit_data(commit_data), .commit_funct3(commit_funct3),
    .sb_full(sb_full), .sb_empty(sb_empty),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_stall(ld_stall), .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
    .err_misaligned(err_misaligned), .err_overflow(err_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_commit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    commit_valid  = 1'b1;
    commit_funct3 = f3;
    commit_addr   = a;
    commit_data   = d;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        bad;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] q[$];

  initial begin
    vecs[0] = '{3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'hDEAD_BEEF};
    vecs[1] = '{3'b000, 32'h0000_0203, 32'h0000_00AB, 1'b0, 4'b1000, 32'hABAB_ABAB};
    vecs[2] = '{3'b001, 32'h0000_0202, 32'h0000_1234, 1'b0, 4'b1100, 32'h1234_1234};
    vecs[3] = '{3'b000, 32'h0000_0200, 32'hFFFF_FF12, 1'b0, 4'b0001, 32'h1212_1212};
    vecs[4] = '{3'b001, 32'h0000_0200, 32'h0000_BEEF, 1'b0, 4'b0011, 32'hBEEF_BEEF};
    vecs[5] = '{3'b001, 32'h0000_0201, 32'h0000_5555, 1'b1, 4'b0000, 32'h0};
    vecs[6] = '{3'b010, 32'h0000_0102, 32'h0000_6666, 1'b1, 4'b0000, 32'h0};
    vecs[7] = '{3'b011, 32'h0000_0104, 32'h0000_7777, 1'b1, 4'b0000, 32'h0};

    rst = 1'b1; commit_valid = 1'b0; commit_addr = '0; commit_data = '0;
    commit_funct3 = '0; mem_ready = 1'b1; ld_valid = 1'b1; ld_addr = 32'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_empty", {31'b0, sb_empty}, 32'd1);
    chk("rst_full", {31'b0, sb_full}, 32'd0);
    chk("rst_ld", {29'b0, ld_stall, ld_fwd_valid, |ld_fwd_data}, 32'd0);
    chk("rst_err", {30'b0, err_misaligned, err_overflow}, 32'd0);

    // Lane placement table, one store at a time with memory always ready
    for (int i = 0; i < 8; i++) begin
      set_commit(vecs[i].f3, vecs[i].addr, vecs[i].data);
      tick();
      commit_valid = 1'b0;
      #1;
      if (vecs[i].bad) begin
        chk($sformatf("v%0d_err", i), {31'b0, err_misaligned}, 32'd1);
        chk($sformatf("v%0d_empty", i), {31'b0, sb_empty}, 32'd1);
        chk($sformatf("v%0d_noreq", i), {31'b0, mem_req}, 32'd0);
      end else begin
        chk($sformatf("v%0d_req", i), {31'b0, mem_req}, 32'd1);
        chk($sformatf("v%0d_addr", i), mem_addr, {vecs[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wdata);
        chk($sformatf("v%0d_wstrb", i), {28'b0, mem_wstrb}, {28'b0, vecs[i].strb});
        chk($sformatf("v%0d_noerr", i), {31'b0, err_misaligned}, 32'd0);
      end
      tick();
      chk($sformatf("v%0d_drained", i), {31'b0, sb_empty}, 32'd1);
      chk($sformatf("v%0d_pulse_end", i), {31'b0, err_misaligned}, 32'd0);
    end

    // Fill to full with memory stalled
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_commit(3'b010, 32'h500 + 32'(4*i), 32'(i + 1));
      q.push_back(32'h500 + 32'(4*i));
      tick();
    end
    commit_valid = 1'b0;
    #1;
    chk("full_set", {31'b0, sb_full}, 32'd1);
    chk("full_no_ovf", {31'b0, err_overflow}, 32'd0);
    set_commit(3'b010, 32'h600, 32'h99);
    tick();
    commit_valid = 1'b0;
    #1;
    chk("ovf_set", {31'b0, err_overflow}, 32'd1);
    chk("ovf_still_full", {31'b0, sb_full}, 32'd1);

    // Push and pop together while full; tail wraps around
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_commit(3'b010, 32'h700 + 32'(4*k), 32'hA0 + 32'(k));
      #1;
      chk($sformatf("pp%0d_head", k), mem_addr, q[0]);
      @(posedge clk);
      void'(q.pop_front());
      q.push_back(32'h700 + 32'(4*k));
      #1;
      chk($sformatf("pp%0d_full", k), {31'b0, sb_full}, 32'd1);
    end
    commit_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("drain%0d_req", k), {31'b0, mem_req}, 32'd1);
      chk($sformatf("drain%0d_addr", k), mem_addr, q[0]);
      @(posedge clk);
      void'(q.pop_front());
    end
    #1;
    chk("drain_empty", {31'b0, sb_empty}, 32'd1);
    chk("ovf_sticky", {31'b0, err_overflow}, 32'd1);

    // Forwarding and stall lookups with memory stalled
    mem_ready = 1'b0;
    set_commit(3'b010, 32'h300, 32'h1111_1111);
    tick();
    set_commit(3'b010, 32'h300, 32'h2222_2222);
    tick();
    commit_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h302;
    #1;
    chk("fwd_valid", {31'b0, ld_fwd_valid}, 32'd1);
    chk("fwd_data", ld_fwd_data, 32'h2222_2222);
    chk("fwd_nostall", {31'b0, ld_stall}, 32'd0);
    set_commit(3'b000, 32'h301, 32'h55);
    tick();
    commit_valid = 1'b0;
    ld_addr = 32'h300;
    #1;
    chk("stall_set", {31'b0, ld_stall}, 32'd1);
    chk("stall_nofwd", {31'b0, ld_fwd_valid}, 32'd0);
    ld_addr = 32'h400;
    #1;
    chk("miss_all0", {29'b0, ld_stall, ld_fwd_valid, |ld_fwd_data}, 32'd0);
    ld_valid = 1'b0; ld_addr = 32'h300;
    #1;
    chk("ldoff_all0", {29'b0, ld_stall, ld_fwd_valid, |ld_fwd_data}, 32'd0);
    ld_valid = 1'b1; ld_addr = 32'h404;
    set_commit(3'b010, 32'h404, 32'hCAFE_F00D);
    #1;
    chk("samecyc_hidden", {30'b0, ld_stall, ld_fwd_valid}, 32'd0);
    tick();
    commit_valid = 1'b0;
    #1;
    chk("nextcyc_fwd", ld_fwd_data, 32'hCAFE_F00D);

    // Reset with pending stores
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_req", {31'b0, mem_req}, 32'd0);
    chk("rst2_empty", {31'b0, sb_empty}, 32'd1);
    chk("rst2_ovf", {31'b0, err_overflow}, 32'd0);
    chk("rst2_ld", {30'b0, ld_stall, ld_fwd_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- FIFO of committed stores between ROB retirement and the data-memory write port.
- Accepts one retired store per cycle from the ROB commit outputs (MemWrite, Addr, value, funct3).
- Generates byte strobes, drains stores in order through a valid/ready memory port, and gives younger loads a stall/forward answer.
- Contents are architectural. Exception and mret do not flush them; only reset clears the buffer.

Parameters:
DEPTH, 8, number of store entries (power of two, at least 2)
PTR_W, 3, log2(DEPTH)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
commit_valid  in  1  retiring store this cycle (ROB out_MemWrite)
commit_addr  in  32  byte address (ROB out_Addr)
commit_data  in  32  store value, low-aligned (ROB out_value)
commit_funct3  in  3  000 SB, 001 SH, 010 SW (ROB ROB_funct3)
sb_full  out  1  count==DEPTH; ROB must not retire a store while high
sb_empty  out  1  count==0; used for fence/mret drain
mem_req  out  1  head entry valid
mem_addr  out  32  head address, word-aligned ({addr[31:2],2'b00})
mem_wdata  out  32  head lane-placed data
mem_wstrb  out  4  head byte strobes
mem_ready  in  1  memory accepts head when mem_req&&mem_ready
ld_valid  in  1  load lookup request
ld_addr  in  32  load byte address
ld_stall  out  1  load overlaps a buffered store and cannot be forwarded
ld_fwd_valid  out  1  forwarding hit
ld_fwd_data  out  32  forwarded word
err_misaligned  out  1  one-cycle pulse: commit dropped, bad alignment or funct3
err_overflow  out  1  sticky: commit arrived while full and no pop
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset values:
  - head, tail and count are 0; all entry valid bits are 0.
  - mem_req=0, sb_empty=1, sb_full=0.
  - ld_stall=0, ld_fwd_valid=0, ld_fwd_data=0.
  - err_misaligned=0, err_overflow=0.
- Reset mid-drain: pending stores are discarded; mem_req is 0 from the cycle after the reset edge.
- Entry contents: {valid, addr[31:2], wdata[31:0], wstrb[3:0]}, computed at push time.
- Lane placement, with a = commit_addr[1:0]:
  - SB: wstrb = 4'b0001<<a; wdata = {4{data[7:0]}}.
  - SH: wstrb = 4'b0011<<{a[1],1'b0}; wdata = {2{data[15:0]}}.
  - SW: wstrb = 4'b1111; wdata = data.
- Illegal commits are not stored. Illegal means SH with a[0]=1, SW with a!=0, or funct3 not in {000,001,010}. Response: err_misaligned pulses one cycle after the commit edge.
- Push: entry written at tail on the edge where commit_valid is high and (count<DEPTH or a pop occurs the same edge). tail advances mod DEPTH.
- Overflow: commit_valid while full with no pop drops the commit and sets err_overflow until reset.
- Pop: on the edge where mem_req&&mem_ready, head is invalidated and advances mod DEPTH.
- Latency: a store pushed at edge N drives mem_req=1 in cycle N+1, so the minimum latency is 1 cycle.
- Memory port:
  - mem_req/mem_addr/mem_wdata/mem_wstrb are derived from registered head state only and stay stable until accepted.
  - Back-to-back pops are allowed, one per cycle.
- Simultaneous push and pop: count is unchanged; a full buffer stays full; push into a one-entry buffer while popping leaves count=1.
- Pointer wrap: head and tail use PTR_W bits and count uses PTR_W+1 bits. sb_full and sb_empty are derived from count, not from pointer equality.
- Load lookup is combinational and has priority to the youngest store.
  - A match is a valid entry with the same addr[31:2].
  - If the youngest matching entry has wstrb==4'b1111: ld_fwd_valid=1, ld_fwd_data=that wdata, ld_stall=0.
  - Otherwise, if any match exists: ld_stall=1, ld_fwd_valid=0.
  - With no match, or ld_valid=0: all three outputs are 0.
  - An entry being popped this cycle still counts as a match.
  - A same-cycle commit is not visible to the lookup until the next cycle.

Test Plan:
- Reset, then SW addr 0x100 data 0xDEADBEEF with mem_ready=1:
  - Next cycle: mem_req=1, mem_addr=0x100, wdata=0xDEADBEEF, wstrb=1111.
  - Following cycle: sb_empty=1.
- SB addr 0x203 data 0x000000AB → wstrb=1000, wdata=0xABABABAB.
- SH addr 0x202 data 0x1234 → wstrb=1100, wdata=0x12341234.
- SH addr 0x201 → err_misaligned pulses 1 cycle; sb_empty stays 1.
- mem_ready=0 and push 8 SW → sb_full=1.
  - A 9th commit sets err_overflow.
  - Then mem_ready=1 with commit held: push+pop keeps count 8.
  - Drain order is FIFO across the wrap.
- Fill 0x300 with SW 0x11111111 then SW 0x22222222; ld_addr=0x302 → ld_fwd_valid=1, ld_fwd_data=0x22222222.
- Add SB 0x301; ld_addr=0x300 → ld_stall=1.
- Lookup of 0x400 → all lookup outputs 0.
- Assert rst with 3 pending stores → next cycle mem_req=0, sb_empty=1, err_overflow=0.
